alu_flag_register: RTL and testbench

Sequential producer of the condition flags consumed by the branch-condition select mux in the RISC-KGP datapath. It derives carry, zero and sign from each flag-setting ALU result, holds them in architectural flag registers, and tracks outstanding flag-setting operations so the branch unit stalls until the flags it tests are current. It sits between the ALU writeback stage and the branch-condition logic.

---
 rtl/risc_kgp_pkg.sv | 36 +++
 rtl/flag_pend_counter.sv | 57 +++++
 rtl/alu_flag_register.sv | 69 ++++++
 tb/tb_alu_flag_register.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_kgp_pkg.sv
// Shared RISC-KGP definitions: branch flag codes, flag bit layout and
// default datapath width.
package risc_kgp_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        FC_ALWAYS = 3'd0,
        FC_CARRY  = 3'd1,
        FC_NCARRY = 3'd2,
        FC_ZERO   = 3'd3,
        FC_SIGN   = 3'd4,
        FC_NZERO  = 3'd5
    } fcode_t;

    localparam int FLAG_C_BIT = 0;
    localparam int FLAG_Z_BIT = 1;
    localparam int FLAG_S_BIT = 2;
    localparam int FLAG_W     = 3;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic flags_t make_flags(
        input logic carry,
        input logic zero,
        input logic sign
    );
        flags_t f;
        f             = '0;
        f[FLAG_C_BIT] = carry;
        f[FLAG_Z_BIT] = zero;
        f[FLAG_S_BIT] = sign;
        return f;
    endfunction

endpackage

// File: rtl/flag_pend_counter.sv
// Saturating count of outstanding flag-setting ops, with flush and
// overflow/underflow event outputs.
module flag_pend_counter #(
    parameter int MAX_PEND = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_flush,
    output logic o_zero,
    output logic o_ovf,
    output logic o_udf
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] MAXV = CW'(MAX_PEND);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_at_max;
    logic          w_at_zero;

    assign w_at_max  = (r_cnt == MAXV);
    assign w_at_zero = (r_cnt == '0);

    // Underflow is flagged even under flush: the completion still had no owner.
    always_comb begin
        w_cnt_nxt = r_cnt;
        o_ovf     = 1'b0;
        o_udf     = i_dec & ~i_inc & w_at_zero;
        if (i_flush) begin
            w_cnt_nxt = '0;
        end else if (i_inc & ~i_dec) begin
            if (w_at_max) begin
                o_ovf = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (i_dec & ~i_inc) begin
            if (!w_at_zero) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_zero = w_at_zero;

endmodule

// File: rtl/alu_flag_register.sv
// Architectural carry/zero/sign flags with outstanding-op tracking so the
// branch unit only samples flags once every flag-setting op has committed.
module alu_flag_register
    import risc_kgp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_PEND = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue,
    input  logic              i_alu_valid,
    input  logic              i_set_flags,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_carry,
    input  logic              i_flush,
    output logic              o_carry,
    output logic              o_zero,
    output logic              o_sign,
    output logic              o_flags_ready,
    output logic              o_err
);

    flags_t r_flags;
    logic   r_err;
    logic   w_cmpl;
    logic   w_pend_zero;
    logic   w_ovf;
    logic   w_udf;

    assign w_cmpl = i_alu_valid & i_set_flags;

    flag_pend_counter #(
        .MAX_PEND (MAX_PEND)
    ) u_pend (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (i_issue),
        .i_dec   (w_cmpl),
        .i_flush (i_flush),
        .o_zero  (w_pend_zero),
        .o_ovf   (w_ovf),
        .o_udf   (w_udf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= '0;
        end else if (w_cmpl) begin
            r_flags <= make_flags(i_carry, i_result == '0,
                                  i_result[DATA_W-1]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_ovf | w_udf) begin
            r_err <= 1'b1;
        end
    end

    assign o_carry       = r_flags[FLAG_C_BIT];
    assign o_zero        = r_flags[FLAG_Z_BIT];
    assign o_sign        = r_flags[FLAG_S_BIT];
    assign o_flags_ready = w_pend_zero;
    assign o_err         = r_err;

endmodule

// File: tb/tb_alu_flag_register.sv
// Directed-vector bench for alu_flag_register: capture, hold, overlap,
// flush, saturation and reset behaviour.
module tb_alu_flag_register;

    localparam int DATA_W = 32;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_issue;
    logic              i_alu_valid;
    logic              i_set_flags;
    logic [DATA_W-1:0] i_result;
    logic              i_carry;
    logic              i_flush;
    logic              o_carry;
    logic              o_zero;
    logic              o_sign;
    logic              o_flags_ready;
    logic              o_err;

    int n_vec = 0;
    int n_bad = 0;

    alu_flag_register #(
        .DATA_W   (DATA_W),
        .MAX_PEND (3)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_issue       (i_issue),
        .i_alu_valid   (i_alu_valid),
        .i_set_flags   (i_set_flags),
        .i_result      (i_result),
        .i_carry       (i_carry),
        .i_flush       (i_flush),
        .o_carry       (o_carry),
        .o_zero        (o_zero),
        .o_sign        (o_sign),
        .o_flags_ready (o_flags_ready),
        .o_err         (o_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic drive(input logic iss, input logic av, input logic sf,
                         input logic [DATA_W-1:0] res, input logic cy,
                         input logic fl);
        i_issue     = iss;
        i_alu_valid = av;
        i_set_flags = sf;
        i_result    = res;
        i_carry     = cy;
        i_flush     = fl;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, '0, 0, 0);
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_carry, o_zero, o_sign} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000",
                     {o_carry, o_zero, o_sign});
        end
        n_vec++;
        if ({o_flags_ready, o_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_rdy_err: got %b want 10",
                     {o_flags_ready, o_err});
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_capture();
        drive(1, 0, 0, '0, 0, 0);
        tick();
        n_vec++;
        if (o_flags_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL cap_issue_rdy: got %b want 0", o_flags_ready);
        end
        drive(0, 1, 1, 32'h0, 1, 0);
        tick();
        n_vec++;
        if ({o_carry, o_zero, o_sign, o_flags_ready} !== 4'b1101) begin
            n_bad++;
            $display("FAIL cap_zero: got czsr=%b want 1101",
                     {o_carry, o_zero, o_sign, o_flags_ready});
        end
        drive(1, 0, 0, '0, 0, 0);
        tick();
        drive(0, 1, 1, 32'h8000_0000, 0, 0);
        tick();
        n_vec++;
        if ({o_carry, o_zero, o_sign, o_flags_ready} !== 4'b0011) begin
            n_bad++;
            $display("FAIL cap_sign: got czsr=%b want 0011",
                     {o_carry, o_zero, o_sign, o_flags_ready});
        end
        drive(0, 0, 0, '0, 0, 0);
        tick();
    endtask

    task automatic test_non_setting();
        drive(1, 0, 0, '0, 0, 0);
        tick();
        drive(0, 1, 0, 32'h0, 1, 0);
        tick();
        n_vec++;
        if ({o_carry, o_zero, o_sign, o_flags_ready} !== 4'b0010) begin
            n_bad++;
            $display("FAIL nonset_hold: got czsr=%b want 0010",
                     {o_carry, o_zero, o_sign, o_flags_ready});
        end
        drive(0, 1, 1, 32'h1, 1, 0);
        tick();
        n_vec++;
        if ({o_carry, o_zero, o_sign, o_flags_ready} !== 4'b1001) begin
            n_bad++;
            $display("FAIL nonset_done: got czsr=%b want 1001",
                     {o_carry, o_zero, o_sign, o_flags_ready});
        end
        drive(0, 0, 0, '0, 0, 0);
        tick();
    endtask

    task automatic test_overlap();
        logic [DATA_W-1:0] res [3];
        logic              cy  [3];
        logic [3:0]        exp [3];
        res = '{32'h0, 32'hFFFF_FFFF, 32'h7};
        cy  = '{1'b1, 1'b0, 1'b1};
        exp = '{4'b1100, 4'b0010, 4'b1001};
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, '0, 0, 0);
            tick();
        end
        drive(1, 1, 1, 32'h10, 0, 0);
        tick();
        n_vec++;
        if ({o_carry, o_zero, o_sign, o_flags_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL ovl_both: got czsr=%b want 0000",
                     {o_carry, o_zero, o_sign, o_flags_ready});
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, res[i], cy[i], 0);
            tick();
            n_vec++;
            if ({o_carry, o_zero, o_sign, o_flags_ready} !== exp[i]) begin
                n_bad++;
                $display("FAIL ovl_cmpl%0d: got czsr=%b want %b", i,
                         {o_carry, o_zero, o_sign, o_flags_ready}, exp[i]);
            end
        end
        n_vec++;
        if (o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovl_err: got %b want 0", o_err);
        end
        drive(0, 0, 0, '0, 0, 0);
        tick();
    endtask

    task automatic test_flush();
        drive(1, 0, 0, '0, 0, 0);
        tick();
        tick();
        drive(1, 1, 1, 32'h5, 0, 1);
        tick();
        n_vec++;
        if ({o_carry, o_zero, o_sign, o_flags_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL flush: got czsr=%b want 0001",
                     {o_carry, o_zero, o_sign, o_flags_ready});
        end
        drive(1, 0, 0, '0, 0, 0);
        tick();
        drive(0, 1, 1, 32'h5, 0, 0);
        tick();
        n_vec++;
        if ({o_flags_ready, o_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL flush_after: got re=%b want 10",
                     {o_flags_ready, o_err});
        end
        drive(0, 0, 0, '0, 0, 0);
        tick();
    endtask

    task automatic test_errors();
        drive(1, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if ({o_flags_ready, o_err} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_full: got re=%b want 00",
                     {o_flags_ready, o_err});
        end
        tick();
        n_vec++;
        if ({o_flags_ready, o_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL err_ovf: got re=%b want 01",
                     {o_flags_ready, o_err});
        end
        // pend must have saturated at 3: three completions drain it
        drive(0, 1, 1, 32'h2, 0, 0);
        tick();
        tick();
        n_vec++;
        if (o_flags_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL err_sat2: got %b want 0", o_flags_ready);
        end
        tick();
        n_vec++;
        if (o_flags_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sat3: got %b want 1", o_flags_ready);
        end
        drive(0, 0, 0, '0, 0, 0);
        i_rst_n = 1'b0;
        #2;
        n_vec++;
        if ({o_err, o_flags_ready, o_carry, o_zero, o_sign} !== 5'b01000) begin
            n_bad++;
            $display("FAIL err_reset: got erczs=%b want 01000",
                     {o_err, o_flags_ready, o_carry, o_zero, o_sign});
        end
        i_rst_n = 1'b1;
        drive(0, 1, 1, 32'h8000_0000, 1, 0);
        tick();
        n_vec++;
        if ({o_err, o_flags_ready, o_carry, o_zero, o_sign} !== 5'b11101) begin
            n_bad++;
            $display("FAIL err_udf: got erczs=%b want 11101",
                     {o_err, o_flags_ready, o_carry, o_zero, o_sign});
        end
        drive(0, 0, 0, '0, 0, 0);
        tick();
        n_vec++;
        if (o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", o_err);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_non_setting();
        test_overlap();
        test_flush();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
